// File: rtl/tpu_result_drain.sv
// tpu_result_drain: converts systolic result rows to packed pixels and writes them to memory; DRAIN_CLAMP_EN enables saturation and sat_count
module tpu_result_drain #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              res_valid,
  input  logic [63:0]       res_data,
  output logic              res_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
`ifdef DRAIN_CLAMP_EN
  ,
  output logic [15:0]       sat_count
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] mem [FIFO_DEPTH];
  logic [PW:0] rp, wp;
  logic [ADDR_W-1:0] n, acc, wcnt, acc_nxt, wcnt_nxt;
  logic [31:0] packed_row;
  logic full, empty, push, pop;
`ifdef DRAIN_CLAMP_EN
  logic [2:0] nsat;
  logic [16:0] sat_sum;
`else
  logic unused_hi;
  assign unused_hi = ^{res_data[63:56], res_data[47:40], res_data[31:24], res_data[15:8]};
`endif
  assign empty = rp == wp;
  assign full = rp == {~wp[PW], wp[PW-1:0]};
  assign res_ready = state == RUN && !full && acc != n;
  assign wr_en = !empty && (state == RUN || state == FLUSH);
  assign push = res_valid && res_ready;
  assign pop = wr_en && wr_ready;
  assign acc_nxt = acc + ADDR_W'(push);
  assign wcnt_nxt = wcnt + ADDR_W'(pop);
  assign wr_data = mem[rp[PW-1:0]];
  always_comb begin
    packed_row = '0;
`ifdef DRAIN_CLAMP_EN
    nsat = '0;
    for (int i = 0; i < 4; i++) begin
      packed_row[8*i +: 8] = res_data[16*i+15] ? 8'h00 : |res_data[16*i+8 +: 7] ? 8'hFF : res_data[16*i +: 8];
      nsat = nsat + 3'(res_data[16*i+15] || |res_data[16*i+8 +: 7]);
    end
`else
    for (int i = 0; i < 4; i++) packed_row[8*i +: 8] = res_data[16*i +: 8];
`endif
  end
  // a zero-word frame spends one cycle in RUN, so done lands two cycles after start
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = acc_nxt != n ? RUN : wcnt_nxt == n ? DONE : FLUSH;
      FLUSH:   state_nxt = wcnt_nxt == n ? DONE : FLUSH;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      n <= '0;
      acc <= '0;
      wcnt <= '0;
      wr_addr <= BASE_ADDR;
      rp <= '0;
      wp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      busy <= state_nxt != IDLE;
      done <= state_nxt == DONE;
      if (state == IDLE) begin
        if (start) begin
          n <= num_words;
          acc <= '0;
          wcnt <= '0;
          wr_addr <= BASE_ADDR;
        end
      end else begin
        acc <= acc_nxt;
        wcnt <= wcnt_nxt;
        wr_addr <= wr_addr + ADDR_W'(pop);
      end
      if (push) begin
        mem[wp[PW-1:0]] <= packed_row;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end
`ifdef DRAIN_CLAMP_EN
  assign sat_sum = {1'b0, sat_count} + 17'(nsat);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_count <= '0;
    else if (state == IDLE && start) sat_count <= '0;
    else if (push) sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_tpu_result_drain.sv
// tb_tpu_result_drain: randomized frames against a queue-based reference model, plus directed edge cases
module tb_tpu_result_drain;
  logic clk = 1'b0;
  logic reset, start, res_valid, wr_ready;
  logic [15:0] num_words;
  logic [63:0] res_data;
  logic res_ready, wr_en, busy, done, res_ready2, wr_en2, busy2, done2;
  logic [15:0] wr_addr, wr_addr2;
  logic [31:0] wr_data, wr_data2;
`ifdef DRAIN_CLAMP_EN
  logic [15:0] sat_count, sat_count2;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] pre[$];
  logic [31:0] got[$];

  always #5 clk = ~clk;

  tpu_result_drain dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done)
`ifdef DRAIN_CLAMP_EN
    , .sat_count(sat_count)
`endif
  );

  tpu_result_drain #(.BASE_ADDR(16'hFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ready(wr_ready),
    .busy(busy2), .done(done2)
`ifdef DRAIN_CLAMP_EN
    , .sat_count(sat_count2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lane_val(input logic [63:0] r, input int i);
    logic [15:0] h;
    h = r[16*i +: 16];
    return int'($signed(h));
  endfunction

  function automatic logic [31:0] ref_word(input logic [63:0] r);
    int v;
    int p;
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      v = lane_val(r, i);
`ifdef DRAIN_CLAMP_EN
      p = v < 0 ? 0 : (v > 255 ? 255 : v);
`else
      p = v & 255;
`endif
      w = w | (32'(p) << (8 * i));
    end
    return w;
  endfunction

  function automatic int ref_sat(input logic [63:0] r);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) if (lane_val(r, i) < 0 || lane_val(r, i) > 255) c++;
    return c;
  endfunction

  function automatic logic [15:0] rand_lane();
    return $urandom_range(0, 2) == 0 ? 16'($urandom) : 16'($urandom_range(0, 255));
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_res_ready"}, 64'(res_ready), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'h0);
    check({tag, "_wr_addr_wrap"}, 64'(wr_addr2), 64'hFFFE);
    check({tag, "_wr_data"}, 64'(wr_data), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
`ifdef DRAIN_CLAMP_EN
    check({tag, "_sat"}, 64'(sat_count), 64'd0);
`endif
  endtask

  task automatic run_frame(input int nw, input int vpct, input int rpct, input int stall,
                           input bit restart, input int abort_at, input string tag);
    logic [63:0] rq[$];
    logic [31:0] exp_q[$];
    logic [63:0] r;
    logic [31:0] hold_d;
    logic [15:0] hold_a;
    int acc, wi, cyc, esat, last_wr;
    bit fin, held;
    acc = 0; wi = 0; cyc = 0; esat = 0; last_wr = 0; fin = 0; held = 0;
    hold_d = '0; hold_a = '0;
    for (int i = 0; i < nw; i++) begin
      r = pre.size() > 0 ? pre.pop_front() : {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      rq.push_back(r);
      exp_q.push_back(ref_word(r));
      esat = esat + ref_sat(r);
    end
    if (esat > 65535) esat = 65535;
    got.delete();
    @(negedge clk);
    start = 1'b1; num_words = 16'(nw); res_valid = 1'b0; wr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    while (!fin && cyc < 2000) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      start = restart && cyc == 3;
      num_words = 16'(nw + 3);
      res_valid = acc < nw && (cyc <= stall || $urandom_range(1, 100) <= vpct);
      res_data = acc < nw ? rq[acc] : 64'h0;
      wr_ready = cyc <= stall ? 1'b0 : ($urandom_range(1, 100) <= rpct);
      #1;
      if (stall > 0 && cyc == stall) begin
        check({tag, "_stall_accepted"}, 64'(acc), 64'd4);
        check({tag, "_full_ready"}, 64'(res_ready), 64'd0);
      end
      if (acc - wi == 4) check({tag, "_full_blocks"}, 64'(res_ready), 64'd0);
      if (abort_at > 0 && acc == abort_at) begin
        reset = 1'b1;
        #1;
        check_reset_vals({tag, "_abort"});
        res_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        check({tag, "_no_done"}, 64'(done), 64'd0);
        reset = 1'b0;
        return;
      end
      if (held) begin
        check({tag, "_hold_en"}, 64'(wr_en), 64'd1);
        check({tag, "_hold_data"}, 64'(wr_data), 64'(hold_d));
        check({tag, "_hold_addr"}, 64'(wr_addr), 64'(hold_a));
        held = 0;
      end
      if (wr_en && !wr_ready) begin
        held = 1; hold_d = wr_data; hold_a = wr_addr;
      end
      if (wr_en && wr_ready) begin
        check({tag, "_wr_data"}, 64'(wr_data), wi < nw ? 64'(exp_q[wi]) : 64'hDEAD_0000);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'(16'(wi)));
        check({tag, "_wr_addr_wrap"}, 64'(wr_addr2), 64'(16'(16'hFFFE + wi)));
        check({tag, "_wr_data_wrap"}, 64'(wr_data2), 64'(wr_data));
        got.push_back(wr_data);
        wi++;
        last_wr = cyc;
      end
      if (res_valid && res_ready) acc++;
      if (done) begin
        fin = 1;
        check({tag, "_write_count"}, 64'(wi), 64'(nw));
        check({tag, "_done_timing"}, 64'(cyc), 64'(last_wr + 1));
        check({tag, "_done_wrap"}, 64'(done2), 64'd1);
`ifdef DRAIN_CLAMP_EN
        check({tag, "_sat_count"}, 64'(sat_count), 64'(esat));
`endif
      end
    end
    check({tag, "_finished"}, 64'(fin), 64'd1);
    @(negedge clk);
    start = 1'b0; res_valid = 1'b0;
    #1;
    check({tag, "_done_fall"}, 64'(done), 64'd0);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; res_valid = 1'b0; wr_ready = 1'b0;
    num_words = '0; res_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    pre.push_back({16'd40, 16'd30, 16'd20, 16'd10});
    run_frame(1, 100, 100, 0, 0, 0, "single");
    check("single_word", 64'(got.size() > 0 ? got[0] : 32'h0), 64'h281E140A);

    pre.push_back({16'h0000, 16'h00FF, 16'h012C, 16'hFFFB});
    run_frame(1, 100, 100, 0, 0, 0, "clamp");
`ifdef DRAIN_CLAMP_EN
    check("clamp_word", 64'(got.size() > 0 ? got[0] : 32'h0), 64'h00FFFF00);
    check("clamp_sat", 64'(sat_count), 64'd2);
`else
    check("trunc_word", 64'(got.size() > 0 ? got[0] : 32'h0), 64'h00FF2CFB);
`endif

    run_frame(8, 100, 100, 10, 0, 0, "stall");

    @(negedge clk);
    start = 1'b1; num_words = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zero_busy", 64'(busy), 64'd1);
    check("zero_done_early", 64'(done), 64'd0);
    @(negedge clk);
    #1;
    check("zero_done", 64'(done), 64'd1);
    check("zero_no_write", 64'(wr_en), 64'd0);
    @(negedge clk);
    #1;
    check("zero_done_fall", 64'(done), 64'd0);
    check("zero_busy_fall", 64'(busy), 64'd0);

    run_frame(6, 60, 50, 0, 1, 0, "restart");

    run_frame(5, 100, 0, 0, 0, 2, "abort");
    run_frame(3, 100, 100, 0, 0, 0, "after_reset");

    for (int k = 0; k < 10; k++)
      run_frame($urandom_range(1, 14), $urandom_range(30, 100), $urandom_range(30, 100),
                0, k[0], 0, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
